// File: rtl/srdl2sv_b2r_watchdog.sv
// rtl/srdl2sv_b2r_watchdog.sv - registered bus-to-register stage with access timeout
// Optional error log enabled by defining SRDL2SV_WATCHDOG_ERR_LOG_EN.

package srdl2sv_b2r_watchdog_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  byte_en;
    logic        w_vld;
    logic        r_vld;
  } b2r_t;

  typedef struct packed {
    logic [31:0] data;
    logic        rdy;
    logic        err;
  } r2b_t;
endpackage

module srdl2sv_b2r_watchdog
  import srdl2sv_b2r_watchdog_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  b2r_t       b2r_in,
  output r2b_t       r2b_out,
  output b2r_t       b2r_out,
  input  r2b_t       r2b_in,
  output logic       timeout_pulse,
  output logic [7:0] timeout_cnt
`ifdef SRDL2SV_WATCHDOG_ERR_LOG_EN
  ,
  input  logic        err_log_clr,
  output logic        err_log_vld,
  output logic [31:0] err_addr,
  output logic        err_wr
`endif
);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP, TOUT} state_t;

  // Last counter value of the wait window; zero when the timeout is disabled.
  localparam logic [CNT_W-1:0] LAST_CNT =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      resp_data;
  logic             resp_err;
  logic             req_wr;
  logic             req_vld;
  logic             expired;

  assign req_vld = b2r_in.w_vld | b2r_in.r_vld;
  assign expired = (TIMEOUT_CYCLES != 0) && (wait_cnt == LAST_CNT);
  assign timeout_pulse = (state == TOUT);

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and upstream response; a register rdy beats expiry in the same cycle.
  always_comb begin
    state_nxt = state;
    r2b_out   = '0;
    case (state)
      IDLE:    if (req_vld) state_nxt = ACTIVE;
      ACTIVE: begin
        if (r2b_in.rdy)   state_nxt = RESP;
        else if (expired) state_nxt = TOUT;
      end
      RESP: begin
        r2b_out.rdy  = 1'b1;
        r2b_out.data = resp_data;
        r2b_out.err  = resp_err;
        state_nxt    = IDLE;
      end
      TOUT: begin
        r2b_out.rdy = 1'b1;
        r2b_out.err = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, downstream valid, wait counter and response capture.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      b2r_out   <= '0;
      wait_cnt  <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      req_wr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_vld) begin
            b2r_out.addr    <= b2r_in.addr;
            b2r_out.data    <= b2r_in.data;
            b2r_out.byte_en <= b2r_in.byte_en;
            b2r_out.w_vld   <= b2r_in.w_vld;
            b2r_out.r_vld   <= b2r_in.r_vld & ~b2r_in.w_vld;
            req_wr          <= b2r_in.w_vld;
            wait_cnt        <= '0;
          end
        end
        ACTIVE: begin
          if (r2b_in.rdy) begin
            resp_data     <= r2b_in.data;
            resp_err      <= r2b_in.err;
            b2r_out.w_vld <= 1'b0;
            b2r_out.r_vld <= 1'b0;
          end else if (expired) begin
            b2r_out.w_vld <= 1'b0;
            b2r_out.r_vld <= 1'b0;
          end
          if ((TIMEOUT_CYCLES != 0) && (wait_cnt != LAST_CNT))
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Saturating count of timed-out accesses.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                                   timeout_cnt <= 8'h00;
    else if ((state == TOUT) && (timeout_cnt != 8'hFF)) timeout_cnt <= timeout_cnt + 8'd1;
  end

`ifdef SRDL2SV_WATCHDOG_ERR_LOG_EN
  // Sticky log of the first timed-out access; a timeout coinciding with clear re-arms with the new one.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_log_vld <= 1'b0;
      err_addr    <= '0;
      err_wr      <= 1'b0;
    end else if ((state == TOUT) && (!err_log_vld || err_log_clr)) begin
      err_log_vld <= 1'b1;
      err_addr    <= b2r_out.addr;
      err_wr      <= req_wr;
    end else if (err_log_clr) begin
      err_log_vld <= 1'b0;
    end
  end
`endif

endmodule
